// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: forward-select encoding,
// RV32 major opcodes and the names of the tracked stages after ID.
package hazard_ctrl_pkg;

    localparam int FWD_REGFILE      = 0;
    localparam int FWD_STAGE_OFFSET = 1;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Stage indices for the default three-deep tracker; WB is always DEPTH-1.
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    function automatic int fwd_code(input int stage);
        return stage + FWD_STAGE_OFFSET;
    endfunction

endpackage

// File: rtl/hazard_port_match.sv
// Hazard check for one source-register read port: finds the youngest in-flight
// writer of the source, decides whether its result can be forwarded or must stall.
module hazard_port_match
    import hazard_ctrl_pkg::*;
#(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int FWD_EN     = 1,
    parameter int SW         = 2
) (
    input  logic                  id_valid,
    input  logic [AW-1:0]         rs,
    input  logic                  rs_used,
    input  logic [DEPTH-1:0]      stg_valid,
    input  logic [DEPTH-1:0]      stg_wen,
    input  logic [DEPTH-1:0]      stg_is_load,
    input  logic [DEPTH*AW-1:0]   stg_rd,
    output logic [SW-1:0]         fwd_sel,
    output logic                  stall_req
);

    logic          qualify;
    logic          hit;
    logic          ready;
    logic [SW-1:0] sel;

    assign qualify = id_valid && rs_used && (rs != '0);

    // Scan oldest to youngest so the youngest matching stage is the one that sticks.
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        sel   = SW'(FWD_REGFILE);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (stg_valid[i] && stg_wen[i] && (stg_rd[i*AW +: AW] == rs)) begin
                hit   = 1'b1;
                ready = !stg_is_load[i] || (i >= LOAD_READY);
                sel   = SW'(fwd_code(i));
            end
        end
        hit = hit && qualify;
    end

    always_comb begin
        stall_req = 1'b0;
        fwd_sel   = SW'(FWD_REGFILE);
        if (FWD_EN != 0) begin
            stall_req = hit && !ready;
            if (hit && ready) begin
                fwd_sel = sel;
            end
        end else begin
            stall_req = hit;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destinations after ID and produces
// stall, flush and per-port forward selects, plus saturating stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NRS        = 2,
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int FWD_EN     = 1,
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [NRS*AW-1:0]   id_rs,
    input  logic [NRS-1:0]      id_rs_used,
    input  logic [AW-1:0]       id_rd,
    input  logic                id_wen,
    input  logic                id_is_load,
    input  logic                ex_redirect,
    output logic                stall,
    output logic                flush,
    output logic [NRS*SW-1:0]   fwd_sel,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         flush_cnt
);

    if (DEPTH < 2 || LOAD_READY < 1 || LOAD_READY > DEPTH - 1) begin : g_param_check
        $error("hazard_ctrl: LOAD_READY must lie in 1..DEPTH-1 (DEPTH=1 unsupported)");
    end

    logic [DEPTH-1:0]    stg_valid;
    logic [DEPTH-1:0]    stg_wen;
    logic [DEPTH-1:0]    stg_is_load;
    logic [DEPTH*AW-1:0] stg_rd;
    logic [NRS-1:0]      stall_req;
    logic                issue;

    for (genvar p = 0; p < NRS; p++) begin : g_port
        hazard_port_match #(
            .AW         (AW),
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .FWD_EN     (FWD_EN),
            .SW         (SW)
        ) u_match (
            .id_valid    (id_valid),
            .rs          (id_rs[p*AW +: AW]),
            .rs_used     (id_rs_used[p]),
            .stg_valid   (stg_valid),
            .stg_wen     (stg_wen),
            .stg_is_load (stg_is_load),
            .stg_rd      (stg_rd),
            .fwd_sel     (fwd_sel[p*SW +: SW]),
            .stall_req   (stall_req[p])
        );
    end

    // A taken redirect squashes the ID instruction, so it overrides any hazard stall.
    assign flush = ex_redirect;
    assign stall = (|stall_req) && !ex_redirect;
    assign issue = id_valid && !stall && !ex_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid   <= '0;
            stg_wen     <= '0;
            stg_is_load <= '0;
            stg_rd      <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                stg_valid[k]          <= stg_valid[k-1];
                stg_wen[k]            <= stg_wen[k-1];
                stg_is_load[k]        <= stg_is_load[k-1];
                stg_rd[k*AW +: AW]    <= stg_rd[(k-1)*AW +: AW];
            end
            if (issue) begin
                stg_valid[STG_EX]             <= 1'b1;
                stg_wen[STG_EX]               <= id_wen;
                stg_is_load[STG_EX]           <= id_is_load;
                stg_rd[STG_EX*AW +: AW]       <= id_rd;
            end else begin
                stg_valid[STG_EX]             <= 1'b0;
                stg_wen[STG_EX]               <= 1'b0;
                stg_is_load[STG_EX]           <= 1'b0;
                stg_rd[STG_EX*AW +: AW]       <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus randomized
// traffic checked against an instruction-history reference model.
module tb_hazard_ctrl;

    localparam int NRS        = 2;
    localparam int AW         = 5;
    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 2;
    localparam int SW         = 2;
    localparam int SAT_DEPTH  = 32;
    localparam int SAT_SW     = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic              id_valid = 1'b0;
    logic [NRS*AW-1:0] id_rs = '0;
    logic [NRS-1:0]    id_rs_used = '0;
    logic [AW-1:0]     id_rd = '0;
    logic              id_wen = 1'b0;
    logic              id_is_load = 1'b0;
    logic              ex_redirect = 1'b0;

    logic f_stall, f_flush, n_stall, n_flush, s_stall, s_flush;
    logic [NRS*SW-1:0]     f_fwd_sel, n_fwd_sel;
    logic [NRS*SAT_SW-1:0] s_fwd_sel;
    logic [15:0] f_stall_cnt, f_flush_cnt, n_stall_cnt, n_flush_cnt, s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.NRS(NRS), .AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .FWD_EN(1)) dut_f (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(f_stall), .flush(f_flush), .fwd_sel(f_fwd_sel), .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt));

    hazard_ctrl #(.NRS(NRS), .AW(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .FWD_EN(0)) dut_n (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(n_stall), .flush(n_flush), .fwd_sel(n_fwd_sel), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt));

    hazard_ctrl #(.NRS(NRS), .AW(AW), .DEPTH(SAT_DEPTH), .LOAD_READY(LOAD_READY), .FWD_EN(0)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(s_stall), .flush(s_flush), .fwd_sel(s_fwd_sel), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

    // Reference model: per DUT (0 = forwarding, 1 = no forwarding), the instructions
    // that left ID, youngest first, indexed by how many cycles ago they left.
    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          wen;
        logic          ld;
    } instr_t;

    instr_t            hist[2][DEPTH];
    int unsigned       m_scnt[2];
    int unsigned       m_fcnt;
    logic              exp_stall[2];
    logic [NRS*SW-1:0] exp_sel[2];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < DEPTH; a++) hist[m][a] = '0;
            m_scnt[m]    = 0;
            exp_stall[m] = 1'b0;
            exp_sel[m]   = '0;
        end
        m_fcnt = 0;
    endfunction

    function automatic void predict(input int m);
        logic              any_stall;
        logic [NRS*SW-1:0] sel;
        any_stall = 1'b0;
        sel       = '0;
        for (int p = 0; p < NRS; p++) begin
            int age;
            age = -1;
            if (id_valid && id_rs_used[p] && id_rs[p*AW +: AW] != 0) begin
                for (int a = 0; a < DEPTH; a++) begin
                    if (age < 0 && hist[m][a].v && hist[m][a].wen && hist[m][a].rd == id_rs[p*AW +: AW])
                        age = a;
                end
            end
            if (age >= 0) begin
                if (m == 1) any_stall = 1'b1;
                else if (hist[m][age].ld && age < LOAD_READY) any_stall = 1'b1;
                else sel[p*SW +: SW] = SW'(age + 1);
            end
        end
        exp_stall[m] = any_stall && !ex_redirect;
        exp_sel[m]   = sel;
    endfunction

    function automatic void model_clock();
        for (int m = 0; m < 2; m++) begin
            if (exp_stall[m] && m_scnt[m] < 65535) m_scnt[m]++;
            for (int a = DEPTH - 1; a > 0; a--) hist[m][a] = hist[m][a-1];
            hist[m][0] = '{v: id_valid && !exp_stall[m] && !ex_redirect, rd: id_rd, wen: id_wen, ld: id_is_load};
        end
        if (ex_redirect && m_fcnt < 65535) m_fcnt++;
    endfunction

    task automatic applyStimulus(input logic v, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                                 input logic [1:0] used, input logic [AW-1:0] rd, input logic wen,
                                 input logic ld, input logic redir);
        @(negedge clk);
        id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used;
        id_rd = rd; id_wen = wen; id_is_load = ld; ex_redirect = redir;
        #1;
        predict(0);
        predict(1);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_reset();
        else model_clock();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0; id_rs_used = '0; id_wen = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        predict(0);
        predict(1);
        advance();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 5'd5, 5'd6, 2'b11, 5'd5, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (f_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall got=%b exp=0", f_stall); end
        n_cmp++; if (f_fwd_sel !== '0) begin n_fail++; $display("[TB] FAIL reset_fwd_sel got=%h exp=0", f_fwd_sel); end
        n_cmp++; if (f_flush !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_flush_follows got=%b exp=1", f_flush); end
        n_cmp++; if (s_flush !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_sat_flush got=%b exp=1", s_flush); end
        n_cmp++; if (n_stall !== 1'b0 || s_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_nf_stall got=%b%b exp=00", n_stall, s_stall); end
        n_cmp++; if (s_fwd_sel !== '0) begin n_fail++; $display("[TB] FAIL reset_sat_fwd got=%h exp=0", s_fwd_sel); end
        advance();
        applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (f_flush !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flush_low got=%b exp=0", f_flush); end
        n_cmp++; if (f_stall_cnt !== 16'd0 || f_flush_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_counters got=%0d/%0d exp=0/0", f_stall_cnt, f_flush_cnt); end
        n_cmp++; if (dut_f.stg_valid !== '0) begin n_fail++; $display("[TB] FAIL reset_valids got=%b exp=0", dut_f.stg_valid); end
        advance();
    endtask

    task automatic test_fwd_basic();
        do_reset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (f_fwd_sel[SW-1:0] !== 2'd1) begin n_fail++; $display("[TB] FAIL fwd_ex_sel got=%0d exp=1", f_fwd_sel[SW-1:0]); end
        n_cmp++; if (f_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_ex_stall got=%b exp=0", f_stall); end
        n_cmp++; if (n_stall !== exp_stall[1]) begin n_fail++; $display("[TB] FAIL fwd_ex_nofwd_stall got=%b exp=%b", n_stall, exp_stall[1]); end
        advance();
    endtask

    task automatic test_load_use();
        do_reset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
        advance();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 5'd0, 5'd7, 2'b10, 5'd9, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (f_stall !== (c < 2)) begin n_fail++; $display("[TB] FAIL load_use_stall c=%0d got=%b exp=%b", c, f_stall, c < 2); end
            n_cmp++; if (f_fwd_sel[2*SW-1:SW] !== ((c == 2) ? 2'd3 : 2'd0)) begin n_fail++; $display("[TB] FAIL load_use_sel1 c=%0d got=%0d", c, f_fwd_sel[2*SW-1:SW]); end
            n_cmp++; if (f_stall !== exp_stall[0]) begin n_fail++; $display("[TB] FAIL load_use_model c=%0d got=%b exp=%b", c, f_stall, exp_stall[0]); end
            if (c == 2) begin
                n_cmp++; if (f_stall_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL load_use_cnt got=%0d exp=2", f_stall_cnt); end
            end
            advance();
        end
    endtask

    task automatic test_youngest();
        do_reset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'd3, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (f_fwd_sel[SW-1:0] !== 2'd1) begin n_fail++; $display("[TB] FAIL youngest_sel got=%0d exp=1", f_fwd_sel[SW-1:0]); end
        n_cmp++; if (f_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL youngest_stall got=%b exp=0", f_stall); end
        advance();
    endtask

    task automatic test_x0_nofwd();
        do_reset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (f_fwd_sel !== '0 || f_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_fwd got=%h/%b exp=0/0", f_fwd_sel, f_stall); end
        n_cmp++; if (n_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_nofwd_stall got=%b exp=0", n_stall); end
        advance();
        do_reset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0);
        advance();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        advance();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 5'd4, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (n_stall !== (c < 2)) begin n_fail++; $display("[TB] FAIL nofwd_mem_stall c=%0d got=%b exp=%b", c, n_stall, c < 2); end
            n_cmp++; if (n_fwd_sel !== '0) begin n_fail++; $display("[TB] FAIL nofwd_sel c=%0d got=%h exp=0", c, n_fwd_sel); end
            n_cmp++; if (f_fwd_sel !== exp_sel[0] || f_stall !== exp_stall[0]) begin n_fail++; $display("[TB] FAIL nofwd_peer_fwd c=%0d got=%h/%b exp=%h/%b", c, f_fwd_sel, f_stall, exp_sel[0], exp_stall[0]); end
            advance();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
        advance();
        applyStimulus(1'b1, 5'd7, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (f_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL redirect_stall got=%b exp=0", f_stall); end
        n_cmp++; if (f_flush !== 1'b1) begin n_fail++; $display("[TB] FAIL redirect_flush got=%b exp=1", f_flush); end
        advance();
        applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (dut_f.stg_valid[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL redirect_bubble got=%b exp=0", dut_f.stg_valid[0]); end
        n_cmp++; if (f_flush_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL redirect_flush_cnt got=%0d exp=1", f_flush_cnt); end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 85, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8);
            n_cmp++; if (f_stall !== exp_stall[0]) begin n_fail++; $display("[TB] FAIL rand_f_stall i=%0d got=%b exp=%b", i, f_stall, exp_stall[0]); end
            n_cmp++; if (f_fwd_sel !== exp_sel[0]) begin n_fail++; $display("[TB] FAIL rand_f_sel i=%0d got=%h exp=%h", i, f_fwd_sel, exp_sel[0]); end
            n_cmp++; if (n_stall !== exp_stall[1]) begin n_fail++; $display("[TB] FAIL rand_n_stall i=%0d got=%b exp=%b", i, n_stall, exp_stall[1]); end
            n_cmp++; if (n_fwd_sel !== '0) begin n_fail++; $display("[TB] FAIL rand_n_sel i=%0d got=%h exp=0", i, n_fwd_sel); end
            n_cmp++; if (f_flush !== ex_redirect || n_flush !== ex_redirect) begin n_fail++; $display("[TB] FAIL rand_flush i=%0d got=%b%b exp=%b", i, f_flush, n_flush, ex_redirect); end
            n_cmp++; if (f_stall_cnt !== 16'(m_scnt[0]) || n_stall_cnt !== 16'(m_scnt[1])) begin n_fail++; $display("[TB] FAIL rand_stall_cnt i=%0d got=%0d/%0d exp=%0d/%0d", i, f_stall_cnt, n_stall_cnt, m_scnt[0], m_scnt[1]); end
            n_cmp++; if (f_flush_cnt !== 16'(m_fcnt) || n_flush_cnt !== 16'(m_fcnt)) begin n_fail++; $display("[TB] FAIL rand_flush_cnt i=%0d got=%0d/%0d exp=%0d", i, f_flush_cnt, n_flush_cnt, m_fcnt); end
            advance();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        id_valid = 1'b1; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
        id_rd = 5'd7; id_wen = 1'b1; id_is_load = 1'b1; ex_redirect = 1'b0;
        repeat (70000) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (s_stall_cnt !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL sat_stall_cnt got=%h exp=FFFF", s_stall_cnt); end
        n_cmp++; if (s_flush_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL sat_flush_cnt got=%0d exp=0", s_flush_cnt); end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (s_stall_cnt !== 16'd0 || f_stall_cnt !== 16'd0 || n_stall_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL async_rst_cnt got=%0d/%0d/%0d exp=0", s_stall_cnt, f_stall_cnt, n_stall_cnt); end
        n_cmp++; if (dut_s.stg_valid !== '0 || dut_f.stg_valid !== '0) begin n_fail++; $display("[TB] FAIL async_rst_valid got=%h/%b exp=0", dut_s.stg_valid, dut_f.stg_valid); end
        n_cmp++; if (s_stall !== 1'b0 || s_fwd_sel !== '0) begin n_fail++; $display("[TB] FAIL async_rst_out got=%b/%h exp=0/0", s_stall, s_fwd_sel); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (f_stall !== 1'b0 || n_stall !== 1'b0 || s_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL post_rst_stall got=%b%b%b exp=000", f_stall, n_stall, s_stall); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fwd_basic();
        test_load_use();
        test_youngest();
        test_x0_nofwd();
        test_redirect();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
